// File: rtl/buf_line_arbiter.sv
// Round-robin owner arbiter for a shared buffered line: grants one of four requesters,
// registers its data bit onto the line and inserts one idle turnaround cycle between owners.
// Optional hold-time limit is compiled in with `define BUF_ARB_TIMEOUT_EN.
module buf_line_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic [3:0] D,
    output logic [3:0] GNT,
    output logic       O,
    output logic       O_EN
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN  = 2'b01,
        TURN = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic       o_q, o_d;

    logic       arb_valid;
    logic [1:0] arb_idx;
    logic [1:0] arb_cand;
    logic       grant_load;
    logic       timeout_hit;
    logic       own_active;

    // Rotating priority: candidate ptr+1 is highest, ptr itself lowest, so the
    // last owner (which ptr always names) yields to everyone else.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = ptr_q;
        arb_cand  = '0;
        for (int k = 4; k >= 1; k--) begin
            arb_cand = ptr_q + 2'(k);
            if (REQ[arb_cand]) begin
                arb_valid = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

`ifdef BUF_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_q, hold_d;

    // The edge that would bring the count to MAX_HOLD ends the ownership.
    always_comb begin
        timeout_hit = (state_q == OWN) && (hold_q >= HOLD_LAST);
    end

    always_comb begin
        hold_d = hold_q;
        if (grant_load) begin
            hold_d = '0;
        end else if ((state_q == OWN) && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; TURN arbitrates exactly like IDLE but only after one dead cycle.
    always_comb begin
        state_d    = state_q;
        grant_load = 1'b0;
        case (state_q)
            IDLE, TURN: begin
                if (arb_valid) begin
                    state_d    = OWN;
                    grant_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (!REQ[owner_q] || timeout_hit) begin
                    state_d = TURN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d = owner_q;
        ptr_d   = ptr_q;
        o_d     = o_q;
        if (grant_load) begin
            owner_d = arb_idx;
            ptr_d   = arb_idx;
            o_d     = D[arb_idx];
        end else if (state_d == OWN) begin
            o_d = D[owner_q];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            owner_q <= 2'd0;
            ptr_q   <= 2'd3;
            o_q     <= 1'b0;
        end else begin
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            o_q     <= o_d;
        end
    end

    // Outputs decode straight from the async-reset state, so RST kills them instantly.
    always_comb begin
        own_active = (state_q == OWN);
        O_EN       = |GNT;
        O          = o_q;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_gnt
            assign GNT[gi] = own_active && (owner_q == 2'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_buf_line_arbiter.sv
// Bench for buf_line_arbiter: directed scenarios plus random traffic against an
// owner/pointer reference model. Honours BUF_ARB_TIMEOUT_EN when defined.
module tb_buf_line_arbiter;

    localparam int MH = 4;
`ifdef BUF_ARB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic       o;
    logic       o_en;

    int checks = 0;
    int errors = 0;

    int   m_owner;
    int   m_ptr;
    int   m_cnt;
    logic m_o;

    logic [3:0] prev_gnt;
    logic [3:0] seen[$];
    logic [3:0] rr_exp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] hist[12];

    buf_line_arbiter #(.MAX_HOLD(MH)) dut (
        .CLK (clk),
        .RST (rst),
        .REQ (req),
        .D   (d),
        .GNT (gnt),
        .O   (o),
        .O_EN(o_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_cnt   = 0;
        m_o     = 1'b0;
    endtask

    // One clock edge of the arbitration rules, in terms of who owns the line.
    task automatic model_edge(input logic [3:0] r, input logic [3:0] dd);
        if (m_owner >= 0) begin
            m_cnt++;
            if (!r[m_owner] || (TO && m_cnt >= MH)) m_owner = -1;
            else m_o = dd[m_owner];
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (r[idx]) begin
                    m_owner = idx;
                    m_ptr   = idx;
                    m_cnt   = 0;
                    m_o     = dd[idx];
                    break;
                end
            end
        end
    endtask

    function automatic logic [3:0] exp_gnt();
        return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    endfunction

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge(req, d);
        #1;
        chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt()));
        chk({tag, ".o_en"}, 32'(o_en), 32'(m_owner >= 0));
        chk({tag, ".o"}, 32'(o), 32'(m_o));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        d   = 4'b0000;
        #1;
        chk("rst.gnt", 32'(gnt), 32'h0);
        chk("rst.o_en", 32'(o_en), 32'h0);
        chk("rst.o", 32'(o), 32'h0);
        req = 4'b1111;
        d   = 4'b1111;
        @(posedge clk);
        #1;
        chk("rst_edge.gnt", 32'(gnt), 32'h0);
        chk("rst_edge.o", 32'(o), 32'h0);
        model_reset();
        req = 4'b0000;
        d   = 4'b0000;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        d   = 4'b0000;
        model_reset();

        // First grant after reset goes to the lowest active index
        do_reset();
        req = 4'b0110;
        cycle("first");
        chk("first.grant", 32'(gnt), 32'h2);
        $display("step first_grant: gnt=%b", gnt);
        req = 4'b0000;
        cycle("first_rel");
        cycle("first_idle");

        // Single requester: owns, one turnaround cycle, then idle
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            cycle("single");
            chk("single.own", 32'(gnt), 32'h1);
        end
        req = 4'b0000;
        cycle("single_turn");
        chk("single.turn_oen", 32'(o_en), 32'h0);
        cycle("single_idle");
        chk("single.idle_oen", 32'(o_en), 32'h0);
        $display("step single: done");

        // Round robin with each owner releasing after two cycles
        do_reset();
        seen.delete();
        prev_gnt = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            req = 4'b1111;
            if (m_owner >= 0 && m_cnt == 1) req[m_owner] = 1'b0;
            d = 4'($urandom);
            cycle("rr");
            if (gnt != 4'b0000 && prev_gnt == 4'b0000 && seen.size() < 5) seen.push_back(gnt);
            prev_gnt = gnt;
        end
        chk("rr.count", 32'(seen.size()), 32'd5);
        for (int i = 0; i < seen.size(); i++) begin
            chk("rr.order", 32'(seen[i]), 32'(rr_exp[i]));
            $display("step rr: grant %0d = %b", i, seen[i]);
        end
        req = 4'b0000;
        cycle("rr_end");

        // Data path latency on owner 2
        do_reset();
        req = 4'b0100;
        d   = 4'b0100;
        cycle("data1");
        chk("data.o_first", 32'(o), 32'h1);
        d = 4'b0000;
        cycle("data0");
        chk("data.o_second", 32'(o), 32'h0);
        d = 4'b1011;
        cycle("data_other");
        chk("data.o_only_owner", 32'(o), 32'h0);
        d = 4'b0100;
        cycle("data_back");
        chk("data.o_back", 32'(o), 32'h1);
        $display("step data: o=%b", o);
        req = 4'b0000;
        cycle("data_end");

        // Two requesters held: timeout rotates, otherwise requester 0 keeps the line
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            d = 4'($urandom);
            cycle("hold");
            hist[i] = gnt;
        end
`ifdef BUF_ARB_TIMEOUT_EN
        chk("timeout.own0_last", 32'(hist[3]), 32'h1);
        chk("timeout.turn", 32'(hist[4]), 32'h0);
        chk("timeout.own1", 32'(hist[5]), 32'h2);
        chk("timeout.own1_last", 32'(hist[8]), 32'h2);
`else
        chk("hold.own0_end", 32'(hist[11]), 32'h1);
`endif
        $display("step hold: last gnt=%b", hist[11]);
        req = 4'b0000;
        cycle("hold_end");

        // Asynchronous reset between edges while a requester owns the line
        do_reset();
        req = 4'b0100;
        d   = 4'b0100;
        cycle("async_own");
        chk("async.owning", 32'(gnt), 32'h4);
        #3;
        rst = 1'b1;
        #1;
        chk("async.gnt_now", 32'(gnt), 32'h0);
        chk("async.oen_now", 32'(o_en), 32'h0);
        chk("async.o_now", 32'(o), 32'h0);
        #2;
        rst = 1'b0;
        model_reset();
        req = 4'b1000;
        cycle("async_after");
        chk("async.regrant", 32'(gnt), 32'h8);
        $display("step async_reset: gnt=%b", gnt);
        req = 4'b0000;
        cycle("async_end");

        // Random contention
        do_reset();
        prev_gnt = 4'b0000;
        for (int i = 0; i < 10000; i++) begin
            req = 4'($urandom);
            if (m_owner >= 0 && $urandom_range(3) != 0) req[m_owner] = 1'b1;
            d = 4'($urandom);
            cycle("rnd");
            chk("rnd.onehot", 32'($countones(gnt) <= 1), 32'h1);
            chk("rnd.oen_or", 32'(o_en), 32'(|gnt));
            chk("rnd.gap", 32'(prev_gnt != 4'b0000 && gnt != 4'b0000 && gnt != prev_gnt), 32'h0);
            prev_gnt = gnt;
        end
        $display("step random: 10000 cycles");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/buf_line_arbiter.md
BUF_LINE_ARBITER -- requirements
Module: buf_line_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive cycles one requester may own the line (legal range 2..255).
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1, the reset: asynchronous and active-high.
REQ-004 The block SHALL have port REQ, input, 4, the per-requester line-ownership request.
REQ-005 The block SHALL have port D, input, 4, the per-requester data bit to drive onto the shared buffered line.
REQ-006 The block SHALL have port GNT, output, 4, the one-hot grant (all-zero when no owner).
REQ-007 The block SHALL have port O, output, 1, the registered line-drive value feeding the inverting buffer pair.
REQ-008 The block SHALL have port O_EN, output, 1, the line-drive enable; high only while an owner is granted.

Function
REQ-009 The FSM SHALL have three states: IDLE, OWN, TURN.
REQ-010 In IDLE with REQ nonzero, the FSM SHALL go to OWN on the next edge, granting the first requester with REQ high, searching upward (mod 4) from PTR+1.
REQ-011 PTR (2-bit round-robin pointer) SHALL be loaded with the granted index at the grant edge.
REQ-012 In OWN, GNT SHALL be the one-hot of the owner, O_EN SHALL be 1, and O SHALL equal D[owner] sampled on the previous edge (one-cycle data latency).
REQ-013 In OWN, when REQ[owner] is low at an edge, the FSM SHALL go to TURN.
REQ-014 In TURN, GNT SHALL be 0, O_EN 0, O hold its last value; the FSM SHALL stay exactly one cycle and then go to IDLE, or directly to OWN if REQ is nonzero.
REQ-015 Arbitration leaving TURN SHALL use the updated PTR, so the releasing requester has lowest priority.
REQ-016 A hold counter SHALL clear on entry to OWN and increment each OWN cycle, saturating at MAX_HOLD.
REQ-017 Requests arriving in OWN or TURN SHALL NOT preempt the owner; they are only evaluated at the arbitration points in REQ-010 and REQ-014.
REQ-018 GNT SHALL never have more than one bit set, and O_EN SHALL equal the OR of GNT in every cycle.
REQ-019 REQ at an edge SHALL take priority over the hold counter: if REQ[owner] drops in the same cycle the limit is reached, the FSM SHALL take the ordinary release path.

Reset
REQ-020 While RST is high, the block SHALL be in IDLE with PTR=3, the hold counter at 0, GNT=0, O=0, O_EN=0, independent of CLK.
REQ-021 RST asserted in OWN SHALL drop GNT and O_EN immediately, without waiting for a clock edge.
REQ-022 After RST falls, the first grant SHALL go to the lowest-index active requester (search starts at 0).

Configuration
REQ-023 With macro BUF_ARB_TIMEOUT_EN defined, the FSM SHALL leave OWN for TURN when the hold counter reaches MAX_HOLD, even if REQ[owner] is still high.
REQ-024 Without BUF_ARB_TIMEOUT_EN, the hold counter SHALL be absent, and ownership SHALL end only when REQ[owner] drops.

Verification
REQ-025 Single requester: REQ=0001 for 3 cycles, then 0 -> GNT=0001 and O_EN=1 from edge 1 to edge 3, then one TURN cycle with O_EN=0, then IDLE.
REQ-026 Round robin: REQ=1111 held, with each owner dropping its REQ for one cycle after 2 cycles of ownership -> grant order 0,1,2,3,0, with one TURN cycle between each grant.
REQ-027 Data path: owner 2, D=0100 then 0000 on successive cycles -> O=1 then 0, each one cycle after D is sampled.
REQ-028 Timeout (macro defined, MAX_HOLD=4): REQ=0011 held -> requester 0 owns for 4 cycles, TURN, requester 1 owns for 4 cycles; without the macro, requester 0 owns indefinitely.
REQ-029 Async reset: RST pulsed mid-OWN between clock edges -> GNT=0 and O_EN=0 immediately; after release with REQ=1000, GNT=1000.
REQ-030 Contention check: random REQ/D for 10k cycles -> GNT is always one-hot-or-zero, O_EN equals OR of GNT, and every release is followed by at least one O_EN=0 cycle.
